// File: rtl/pipelined_dual_mode_modmul.sv
// pipelined_dual_mode_modmul
//
// This block is a four-stage pipelined modular multiplier for the NTT
// datapath. Each operation picks its own reduction mode:
//   mode 0 : Barrett,    c = a*b mod Q
//   mode 1 : Montgomery, c = a*b*2^-R_W mod Q
// The mode travels with the operation, so mixed-mode traffic can stream
// back-to-back without bubbles.
//
// When the output is presented but not accepted, the whole pipe stalls.
// Every stage then holds its content, bubbles included.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   in_valid   operand presented
//   in_ready   operand accepted this cycle; driven as ~(out_valid & ~out_ready)
//   in_a/in_b  operands, DATA_W bits each
//   in_mode    0 = Barrett, 1 = Montgomery
//   in_tag     sideband, returned unchanged with the result
//   out_valid  result presented
//   out_ready  downstream accepts the result
//   out_c      reduced result in [0, Q-1]; 0 for out-of-range operands
//   out_tag    tag of this result
//   out_err    an operand was >= Q
//   occupancy  number of valid operations held in the pipe (0..4)

module pipelined_dual_mode_modmul #(
  parameter int DATA_W = 14,
  parameter int Q      = 12289,
  parameter int R_W    = 16,
  parameter int TAG_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  input  logic              in_mode,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_c,
  output logic [TAG_W-1:0]  out_tag,
  output logic              out_err,
  output logic [2:0]        occupancy
);

  // Width of the full product a*b.
  localparam int P_W = 2 * DATA_W;

  // Width of the partially reduced value; it holds anything below 3Q.
  localparam int R_BITS = DATA_W + 2;

  // Width of p * BARRETT_K.
  localparam int BK_W = 4 * DATA_W;

  // Width of p + m*Q, with one carry bit.
  localparam int MQ_W = ((P_W > R_W + DATA_W) ? P_W : R_W + DATA_W) + 1;

  // The S2 quotient slot holds either t (P_W bits) or m (R_W bits).
  localparam int T_W = (P_W > R_W) ? P_W : R_W;

  function automatic logic [P_W-1:0] calc_barrett_k();
    logic [63:0] k;
    k = (64'd1 << P_W) / 64'(Q);
    return k[P_W-1:0];
  endfunction

  // Newton iteration for Q^-1 mod 2^64. An odd Q is its own inverse
  // mod 8, and each iteration doubles the number of correct low bits,
  // so five iterations are more than enough for R_W <= 18.
  function automatic logic [R_W-1:0] calc_qinv_neg();
    logic [63:0] x;
    logic [63:0] qq;
    qq = 64'(Q);
    x  = qq;
    for (int i = 0; i < 5; i++) begin
      x = x * (64'd2 - qq * x);
    end
    x = 64'd0 - x;
    return x[R_W-1:0];
  endfunction

  localparam logic [P_W-1:0]    BARRETT_K = calc_barrett_k();
  localparam logic [R_W-1:0]    QINV_NEG  = calc_qinv_neg();
  localparam logic [DATA_W-1:0] Q_D       = DATA_W'(Q);
  localparam logic [R_BITS-1:0] Q_R       = R_BITS'(Q);
  localparam logic [MQ_W-1:0]   Q_MQ      = MQ_W'(Q);

  // Pipeline registers
  logic              s1_valid, s2_valid, s3_valid, s4_valid;
  logic              s1_mode,  s2_mode,  s3_mode;
  logic              s1_err,   s2_err,   s3_err,   s4_err;
  logic [TAG_W-1:0]  s1_tag,   s2_tag,   s3_tag,   s4_tag;
  logic [P_W-1:0]    s1_p,     s2_p;
  logic [T_W-1:0]    s2_q;
  logic [R_BITS-1:0] s3_r;
  logic [DATA_W-1:0] s4_c;

  logic              stall, advance, accept, deliver;
  logic [2:0]        occ;

  // Combinational stage logic
  logic [P_W-1:0]    prod;
  logic              in_err;
  logic [BK_W-1:0]   bprod;
  logic [P_W-1:0]    t_next;
  logic [R_W-1:0]    m_next;
  logic [T_W-1:0]    q_next;
  logic [R_BITS-1:0] r_barrett;
  logic [MQ_W-1:0]   mont_sum;
  logic [R_BITS-1:0] r_mont;
  logic [R_BITS-1:0] r_next;
  logic [R_BITS-1:0] r1;
  logic [R_BITS-1:0] r2;
  logic [DATA_W-1:0] c_next;

  assign stall     = s4_valid & ~out_ready;
  assign advance   = ~stall;
  assign in_ready  = advance;
  assign accept    = in_valid & in_ready;
  assign deliver   = s4_valid & out_ready;

  assign out_valid = s4_valid;
  assign out_c     = s4_c;
  assign out_tag   = s4_tag;
  assign out_err   = s4_err;
  assign occupancy = occ;

  always_comb begin
    prod      = '0;
    in_err    = 1'b0;
    bprod     = '0;
    t_next    = '0;
    m_next    = '0;
    q_next    = '0;
    r_barrett = '0;
    mont_sum  = '0;
    r_mont    = '0;
    r_next    = '0;
    r1        = '0;
    r2        = '0;
    c_next    = '0;

    // S1: full product and range check
    prod   = P_W'(in_a) * P_W'(in_b);
    in_err = (in_a >= Q_D) | (in_b >= Q_D);

    // S2: Barrett quotient estimate, or Montgomery m
    bprod  = BK_W'(s1_p) * BK_W'(BARRETT_K);
    t_next = P_W'(bprod >> P_W);
    m_next = R_W'(T_W'(s1_p)) * QINV_NEG;
    q_next = s1_mode ? T_W'(m_next) : T_W'(t_next);

    // S3: Barrett only needs the low R_BITS bits of p - t*Q, because
    // the true value is known to lie in [0, 3Q).
    r_barrett = R_BITS'(s2_p) - R_BITS'(s2_q) * Q_R;
    mont_sum  = MQ_W'(s2_p) + MQ_W'(R_W'(s2_q)) * Q_MQ;
    r_mont    = R_BITS'(mont_sum >> R_W);
    r_next    = s2_mode ? r_mont : r_barrett;

    // S4: Montgomery leaves [0, 2Q), so one subtract is enough.
    // Barrett leaves [0, 3Q), so it may take a second subtract.
    r1 = (s3_r >= Q_R) ? s3_r - Q_R : s3_r;
    r2 = (!s3_mode && (r1 >= Q_R)) ? r1 - Q_R : r1;
    c_next = s3_err ? '0 : DATA_W'(r2);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid <= 1'b0;
      s1_mode  <= 1'b0;
      s1_err   <= 1'b0;
      s1_tag   <= '0;
      s1_p     <= '0;
      s2_valid <= 1'b0;
      s2_mode  <= 1'b0;
      s2_err   <= 1'b0;
      s2_tag   <= '0;
      s2_p     <= '0;
      s2_q     <= '0;
      s3_valid <= 1'b0;
      s3_mode  <= 1'b0;
      s3_err   <= 1'b0;
      s3_tag   <= '0;
      s3_r     <= '0;
      s4_valid <= 1'b0;
      s4_err   <= 1'b0;
      s4_tag   <= '0;
      s4_c     <= '0;
    end else if (advance) begin
      s1_valid <= in_valid;
      s1_mode  <= in_mode;
      s1_err   <= in_err;
      s1_tag   <= in_tag;
      s1_p     <= prod;

      s2_valid <= s1_valid;
      s2_mode  <= s1_mode;
      s2_err   <= s1_err;
      s2_tag   <= s1_tag;
      s2_p     <= s1_p;
      s2_q     <= q_next;

      s3_valid <= s2_valid;
      s3_mode  <= s2_mode;
      s3_err   <= s2_err;
      s3_tag   <= s2_tag;
      s3_r     <= r_next;

      s4_valid <= s3_valid;
      s4_err   <= s3_err;
      s4_tag   <= s3_tag;
      s4_c     <= c_next;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      occ <= 3'd0;
    end else if (accept && !deliver) begin
      if (occ != 3'd4) occ <= occ + 3'd1;
    end else if (deliver && !accept) begin
      if (occ != 3'd0) occ <= occ - 3'd1;
    end
  end

endmodule
